// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor and its resolution partner.
//   SNT/WNT/WT/ST : 2-bit saturating predictor state encodings.
//   cnt_width()   : width of an occupancy counter able to hold 0..depth.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // One extra bit so that "completely full" (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_resolver_if
// Bundles the fetch, execute and predictor-facing signals of branch_resolver.
//   slave  : the resolver (receives issue/prediction/outcome, drives the rest)
//   master : the environment (fetch, execute and predictor)
// ---------------------------------------------------------------------------
interface branch_resolver_if #(
  parameter int CNT_W = 16
) ();

  logic             issue;          // fetch has a branch this cycle
  logic             request;        // prediction request to the predictor
  logic             prediction;     // predictor answer, cycle after request
  logic             outcome_valid;  // execute resolves the oldest branch
  logic             outcome_taken;  // actual direction
  logic             result;         // training strobe to the predictor
  logic             taken;          // actual direction with result
  logic             mispredict;     // front-end redirect pulse
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic             underflow;      // sticky: outcome seen with nothing queued

  modport slave (
    input  issue, prediction, outcome_valid, outcome_taken,
    output request, result, taken, mispredict, full, empty,
           hit_count, miss_count, underflow
  );

  modport master (
    output issue, prediction, outcome_valid, outcome_taken,
    input  request, result, taken, mispredict, full, empty,
           hit_count, miss_count, underflow
  );

endinterface

// File: rtl/pred_fifo.sv
// ---------------------------------------------------------------------------
// pred_fifo
// Circular FIFO of 1-bit predictions.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : synchronous flush; wins over a same-cycle push
//   i_push    : write i_din at the tail
//   i_pop     : drop the head (caller guarantees o_count > 0)
//   o_head    : oldest stored prediction
//   o_count   : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module pred_fifo
  import bp_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_head,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      // NOTE: storage is reset too; it is only DEPTH flops, and a cleared
      // queue then reads back as all-zero instead of stale predictions.
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Issues prediction requests, captures the returned predictions in order,
// compares them with execute outcomes, trains the predictor, raises
// mispredict flushes and keeps saturating hit/miss statistics.
//   clk, rst : clock, synchronous active-high reset
//   br       : branch_resolver_if.slave (fetch / execute / predictor signals)
// ---------------------------------------------------------------------------
module branch_resolver
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolver_if.slave  br
);

  localparam int CW = cnt_width(DEPTH);

  logic             w_head;
  logic [CW-1:0]    w_count;
  logic             w_occupied;
  logic             w_pop;
  logic             w_mismatch;
  logic             w_flush;
  logic             w_full;
  logic             w_request;

  logic             r_pend;
  logic             r_result;
  logic             r_taken;
  logic             r_mispredict;
  logic             r_underflow;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;

  // The capture stage counts against capacity so a prediction in flight
  // always has a free slot when it lands.
  assign w_occupied = (w_count != '0);
  assign w_full     = ((w_count + CW'(r_pend)) == CW'(DEPTH));
  assign w_pop      = br.outcome_valid & w_occupied;
  assign w_mismatch = w_head ^ br.outcome_taken;
  assign w_flush    = w_pop & w_mismatch;
  // A mispredict redirects fetch, so the branch presented alongside it is
  // on the wrong path and must not be accepted.
  assign w_request  = br.issue & ~w_full & ~w_flush;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_flush),
    .i_push  (r_pend),
    .i_din   (br.prediction),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= 1'b0;
      r_result     <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_underflow  <= 1'b0;
      r_hit        <= '0;
      r_miss       <= '0;
    end else begin
      // w_request is already 0 during a flush, so pend clears then as well.
      r_pend       <= w_request;
      r_result     <= w_pop;
      r_taken      <= w_pop & br.outcome_taken;
      r_mispredict <= w_flush;
      // An outcome with nothing queued is an error even if a capture is
      // pending: the outcome must not overtake its own prediction.
      if (br.outcome_valid && !w_occupied) begin
        r_underflow <= 1'b1;
      end
      if (w_pop && !w_mismatch && (r_hit != '1)) begin
        r_hit <= r_hit + CNT_W'(1);
      end
      if (w_flush && (r_miss != '1)) begin
        r_miss <= r_miss + CNT_W'(1);
      end
    end
  end

  assign br.request    = w_request;
  assign br.full       = w_full;
  assign br.empty      = ~w_occupied & ~r_pend;
  assign br.result     = r_result;
  assign br.taken      = r_taken;
  assign br.mispredict = r_mispredict;
  assign br.underflow  = r_underflow;
  assign br.hit_count  = r_hit;
  assign br.miss_count = r_miss;

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side partner of the 2-bit branch predictor. It issues prediction requests when the front end fetches a branch and captures the returned predictions in order. It compares each prediction with the actual outcome from execute. It drives the `result`/`taken` training pulses back into the predictor, signals mispredict flushes, and keeps hit/miss statistics. It sits between fetch, execute and the predictor.

## Interface
Parameters:
- `DEPTH`, 4: maximum number of in-flight (predicted, unresolved) branches; power of two, at least 2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `issue`, in, 1: fetch has a branch this cycle.
- `request`, out, 1: to predictor; combinational, `issue & ~full & ~flush_now`.
- `prediction`, in, 1: from predictor; valid in the cycle after `request`.
- `outcome_valid`, in, 1: execute resolves the oldest branch this cycle.
- `outcome_taken`, in, 1: actual direction; qualified by `outcome_valid`.
- `result`, out, 1: to predictor; registered one-cycle training strobe.
- `taken`, out, 1: to predictor; actual direction accompanying `result`.
- `mispredict`, out, 1: registered one-cycle pulse; front end must redirect.
- `full`, out, 1: occupancy plus pending capture equals `DEPTH`.
- `empty`, out, 1: occupancy is 0 and no capture is pending.
- `hit_count`, out, `CNT_W`: correct predictions, saturating.
- `miss_count`, out, `CNT_W`: mispredictions, saturating.
- `underflow`, out, 1: sticky; set when `outcome_valid` arrives with the queue empty.

## Operation
- Queue: circular FIFO of `DEPTH` 1-bit predictions with read/write pointers and an occupancy count of width clog2(DEPTH)+1.
- Capture stage: a `pend` flag is set on any cycle where `request` is 1. The cycle after, `prediction` is pushed into the queue and `pend` clears unless a new request is made in that cycle.
- Resolve: when `outcome_valid` is 1 and `count > 0`:
  - pop the head;
  - `mismatch = head ^ outcome_taken`;
  - the next cycle, `result=1`, `taken=outcome_taken`, `mispredict=mismatch`;
  - increment `hit_count` or `miss_count`; each holds at all-ones.
- `flush_now = outcome_valid & (count>0) & mismatch`. On that edge:
  - the queue empties (pointers equal, count 0);
  - `pend` clears, and a prediction arriving in the following cycle is dropped;
  - the branch's `request` in that cycle is blocked.
- `outcome_valid` with `count == 0`:
  - no pop, no `result`;
  - `underflow` goes to 1 and stays there until reset.
  - This holds even if `pend` is set, because the outcome must not race its own prediction.
- Simultaneous push and pop with no mismatch: count unchanged, both pointers advance.
- `issue` while `full`: `request` stays 0 and the branch is not accepted. Fetch must hold `issue`.

## Timing
- Reset values: `result=0`, `taken=0`, `mispredict=0`, `hit_count=0`, `miss_count=0`, `underflow=0`, `full=0`, `empty=1`. Queue, pointers and `pend` are cleared.
- Reset mid-operation discards all in-flight entries. A prediction arriving in the cycle after reset is ignored.
- Latency:
  - from `issue` to queue entry: 1 cycle after `request`;
  - from `outcome_valid` to `result`/`mispredict`: 1 cycle.
- The earliest cycle a branch issued in cycle N can resolve is N+2.
- `full` and `empty` are derived from registered state, so they are glitch-free within a cycle apart from reset.
- `result` never asserts on two consecutive cycles unless `outcome_valid` does.

## Structure
- Shared package `bp_pkg`: localparams for the predictor state encodings (`SNT=0`, `WNT=1`, `WT=2`, `ST=3`), plus a helper function for the counter width.
- One sub-module, `pred_fifo`, holds the 1-bit storage, pointers, count, push/pop and a synchronous clear. Compare, capture, counters and flush logic stay in `branch_resolver`.

## Test plan
- **Single hit.** After reset, pulse `issue` in cycle 1 and return `prediction=1` in cycle 2. Drive `outcome_valid=1`, `outcome_taken=1` in cycle 4. Required: cycle 5 shows `result=1`, `taken=1`, `mispredict=0`, and `hit_count=1`.
- **Fill.** Issue 4 branches back-to-back (`DEPTH=4`). Required: `full=1` after the 4th request, and a 5th `issue` gives `request=0`. One resolve, then `issue` gives `request=1`.
- **Mispredict flush.** Queue holds predictions 1,1,1. Resolve with `outcome_taken=0`. Required: `mispredict=1` for one cycle, `miss_count=1`, `empty=1`, and a same-cycle `issue` is blocked.
- **Underflow.** Drive `outcome_valid` with the queue empty. Required: `underflow=1` and sticky, `result=0`, counters unchanged.
- **Saturation.** With `CNT_W=2`, resolve 5 hits. Required: `hit_count=3`.
- **Reset mid-flight.** Assert `rst` with 2 entries queued and `pend=1`. Required: all outputs at their reset values, and the late prediction is not pushed (`empty=1`).
